// File: rtl/elevator_pkg.sv
// Shared types for the elevator request dispatcher.
// Holds the FSM state encoding and the default floor count.
package elevator_pkg;

  localparam int NUM_FLOORS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    REQUEST,
    WAIT_ARRIVE
  } dispatch_state_t;

endpackage

// File: rtl/elevator_request_dispatch_if.sv
// Destination handshake between dispatcher and car.
// master = dispatcher, slave = car controller.
interface elevator_request_dispatch_if #(
  parameter int FLOOR_W = 3
);

  logic               request;
  logic [FLOOR_W-1:0] requested_floor;
  logic               ack;
  logic               arrived;

  modport master (
    output request,
    output requested_floor,
    input  ack,
    input  arrived
  );

  modport slave (
    input  request,
    input  requested_floor,
    output ack,
    output arrived
  );

endinterface

// File: rtl/elevator_floor_select.sv
// Combinational target picker: current floor first, then
// nearest in sweep direction, then nearest behind (flip).
module elevator_floor_select #(
  parameter  int NUM_FLOORS = 8,
  localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  direction,
  output logic [FLOOR_W-1:0]    target,
  output logic                  found,
  output logic                  flip
);

  logic               here_hit;
  logic               up_hit;
  logic               dn_hit;
  logic [FLOOR_W-1:0] up_idx;
  logic [FLOOR_W-1:0] dn_idx;

  // Ascending scan: first hit above is nearest,
  // last hit below is nearest.
  always_comb begin
    here_hit = 1'b0;
    up_hit   = 1'b0;
    dn_hit   = 1'b0;
    up_idx   = '0;
    dn_idx   = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i]) begin
        if (FLOOR_W'(i) == car_floor) begin
          here_hit = 1'b1;
        end else if (FLOOR_W'(i) > car_floor) begin
          if (!up_hit) begin
            up_hit = 1'b1;
            up_idx = FLOOR_W'(i);
          end
        end else begin
          dn_hit = 1'b1;
          dn_idx = FLOOR_W'(i);
        end
      end
    end
  end

  always_comb begin
    target = car_floor;
    found  = 1'b0;
    flip   = 1'b0;
    if (here_hit) begin
      found = 1'b1;
    end else if (direction) begin
      if (up_hit) begin
        target = up_idx;
        found  = 1'b1;
      end else if (dn_hit) begin
        target = dn_idx;
        found  = 1'b1;
        flip   = 1'b1;
      end
    end else begin
      if (dn_hit) begin
        target = dn_idx;
        found  = 1'b1;
      end else if (up_hit) begin
        target = up_idx;
        found  = 1'b1;
        flip   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_request_dispatch.sv
// Call-button collector and destination dispatcher for one car,
// with ack timeout and re-selection.
module elevator_request_dispatch
  import elevator_pkg::*;
#(
  parameter  int NUM_FLOORS  = NUM_FLOORS_DEF,
  parameter  int ACK_TIMEOUT = 16,
  localparam int FLOOR_W     = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_buttons,
  input  logic [FLOOR_W-1:0]    car_floor,
  elevator_request_dispatch_if.master car,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  direction,
  output logic                  busy
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  dispatch_state_t state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic [FLOOR_W-1:0]    target_q, target_d;
  logic                  dir_q, dir_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic [FLOOR_W-1:0] sel_target;
  logic               sel_found;
  logic               sel_flip;

  elevator_floor_select #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_select (
    .pending   (pending_q),
    .car_floor (car_floor),
    .direction (dir_q),
    .target    (sel_target),
    .found     (sel_found),
    .flip      (sel_flip)
  );

  // Arrival clear beats a same-cycle press of the target floor.
  always_comb begin
    clr_mask = '0;
    if (state_q == WAIT_ARRIVE && car.arrived) begin
      clr_mask = NUM_FLOORS'(1) << target_q;
    end
    pending_d = (pending_q | call_buttons) & ~clr_mask;
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dir_d    = dir_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      IDLE: begin
        if ((pending_q | call_buttons) != '0) begin
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (sel_found) begin
          target_d = sel_target;
          tmo_d    = '0;
          state_d  = REQUEST;
          if (sel_flip) begin
            dir_d = ~dir_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQUEST: begin
        if (car.ack) begin
          state_d = WAIT_ARRIVE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = SELECT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_ARRIVE: begin
        if (car.arrived) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      target_q  <= '0;
      dir_q     <= 1'b1;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      dir_q     <= dir_d;
      tmo_q     <= tmo_d;
    end
  end

  assign car.request         = (state_q == REQUEST);
  assign car.requested_floor = target_q;
  assign pending             = pending_q;
  assign direction           = dir_q;
  assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_request_dispatch.sv
// Directed + random bench for elevator_request_dispatch
// against a trip-level reference model.
module tb_elevator_request_dispatch;

  localparam int NF = 8;
  localparam int AT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] call_buttons;
  logic [2:0]    car_floor;
  logic [NF-1:0] pending;
  logic          direction;
  logic          busy;

  int errors = 0;
  int checks = 0;

  logic [NF-1:0] m_pend;
  logic          m_dir;
  int            m_car;

  elevator_request_dispatch_if #(.FLOOR_W(3)) bus ();

  elevator_request_dispatch #(
    .NUM_FLOORS  (NF),
    .ACK_TIMEOUT (AT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .call_buttons (call_buttons),
    .car_floor    (car_floor),
    .car          (bus.master),
    .pending      (pending),
    .direction    (direction),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, 32'(bus.request), 0);
    chk({tag, "_flr"}, 32'(bus.requested_floor), 0);
    chk({tag, "_pend"}, 32'(pending), 0);
    chk({tag, "_dir"}, 32'(direction), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Search outward by distance: current floor, then ahead, then behind.
  task automatic pick(input logic [NF-1:0] p, input int car,
                      input logic dir, output int tgt,
                      output logic nd);
    int f;
    bit hit;
    tgt = car;
    nd  = dir;
    hit = p[car];
    for (int d = 1; d < NF && !hit; d++) begin
      f = dir ? car + d : car - d;
      if (f >= 0 && f < NF && p[f]) begin
        hit = 1;
        tgt = f;
      end
    end
    for (int d = 1; d < NF && !hit; d++) begin
      f = dir ? car - d : car + d;
      if (f >= 0 && f < NF && p[f]) begin
        hit = 1;
        tgt = f;
        nd  = !dir;
      end
    end
  endtask

  initial begin
    logic [NF-1:0] m;
    logic [NF-1:0] cb;
    logic          nd;
    int            tgt;
    int            w;
    int            k;

    reset        = 1'b1;
    call_buttons = '1;
    car_floor    = 3'd0;
    bus.ack      = 1'b0;
    bus.arrived  = 1'b0;
    tick();
    tick();
    chk_reset("por");

    reset        = 1'b0;
    call_buttons = '0;
    car_floor    = 3'd2;
    tick();
    chk("idle_busy", 32'(busy), 0);

    call_buttons = 8'h22;
    tick();
    call_buttons = '0;
    chk("lat_req0", 32'(bus.request), 0);
    chk("lat_busy", 32'(busy), 1);
    chk("lat_pend", 32'(pending), 32'h22);
    tick();
    chk("up_req", 32'(bus.request), 1);
    chk("up_flr", 32'(bus.requested_floor), 5);
    chk("up_dir", 32'(direction), 1);

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_req", 32'(bus.request), 1);
      chk("hold_flr", 32'(bus.requested_floor), 5);
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("ack_drop", 32'(bus.request), 0);
    chk("ack_busy", 32'(busy), 1);

    car_floor   = 3'd5;
    bus.arrived = 1'b1;
    tick();
    bus.arrived = 1'b0;
    chk("arr_pend", 32'(pending), 32'h02);
    chk("arr_busy", 32'(busy), 0);
    tick();
    chk("sel_req", 32'(bus.request), 0);
    chk("sel_busy", 32'(busy), 1);
    tick();
    chk("dn_req", 32'(bus.request), 1);
    chk("dn_flr", 32'(bus.requested_floor), 1);
    chk("dn_dir", 32'(direction), 0);

    car_floor    = 3'd0;
    call_buttons = 8'h01;
    tick();
    call_buttons = '0;
    chk("late_flr", 32'(bus.requested_floor), 1);
    chk("late_req", 32'(bus.request), 1);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("tmo_hold", 32'(bus.request), 1);
    end
    tick();
    chk("tmo_drop", 32'(bus.request), 0);
    chk("tmo_pend", 32'(pending), 32'h03);
    tick();
    chk("tmo_req", 32'(bus.request), 1);
    chk("tmo_flr", 32'(bus.requested_floor), 0);
    chk("tmo_dir", 32'(direction), 0);

    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.arrived = 1'b1;
    tick();
    bus.arrived = 1'b0;
    chk("f0_pend", 32'(pending), 32'h02);
    tick();
    tick();
    chk("f1_flr", 32'(bus.requested_floor), 1);
    chk("f1_dir", 32'(direction), 1);
    bus.ack = 1'b1;
    tick();
    bus.ack     = 1'b0;
    car_floor   = 3'd1;
    bus.arrived = 1'b1;
    tick();
    bus.arrived = 1'b0;
    chk("f1_pend", 32'(pending), 0);

    call_buttons = 8'h08;
    tick();
    call_buttons = '0;
    tick();
    chk("t3_flr", 32'(bus.requested_floor), 3);
    bus.arrived = 1'b1;
    tick();
    bus.arrived = 1'b0;
    chk("spur_req", 32'(bus.request), 1);
    chk("spur_pend", 32'(pending), 32'h08);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    call_buttons = 8'h48;
    bus.arrived  = 1'b1;
    car_floor    = 3'd3;
    tick();
    call_buttons = '0;
    bus.arrived  = 1'b0;
    chk("clr_win", 32'(pending), 32'h40);
    tick();
    tick();
    chk("t6_flr", 32'(bus.requested_floor), 6);
    bus.ack = 1'b1;
    tick();
    bus.ack     = 1'b0;
    car_floor   = 3'd6;
    bus.arrived = 1'b1;
    tick();
    bus.arrived = 1'b0;
    chk("t6_pend", 32'(pending), 0);

    car_floor    = 3'd4;
    call_buttons = 8'h10;
    tick();
    call_buttons = '0;
    tick();
    chk("here_flr", 32'(bus.requested_floor), 4);
    chk("here_dir", 32'(direction), 1);
    bus.ack = 1'b1;
    tick();
    bus.ack     = 1'b0;
    bus.arrived = 1'b1;
    tick();
    bus.arrived = 1'b0;
    chk("here_pend", 32'(pending), 0);
    chk("here_busy", 32'(busy), 0);
    tick();
    chk("here_idle", 32'(busy), 0);

    for (int r = 0; r < 2; r++) begin
      call_buttons = 8'h04;
      tick();
      call_buttons = '0;
      tick();
      chk("pre_rst_req", 32'(bus.request), 1);
      if (r == 1) begin
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
      end
      reset        = 1'b1;
      call_buttons = '1;
      tick();
      reset        = 1'b0;
      call_buttons = '0;
      chk_reset("mid_rst");
      tick();
      chk("post_rst_busy", 32'(busy), 0);
    end

    m_pend = '0;
    m_dir  = 1'b1;
    m_car  = 4;
    for (int t = 0; t < 40; t++) begin
      m = NF'($urandom);
      if (m_pend == '0 && m == '0) begin
        m = NF'(1) << $urandom_range(0, NF - 1);
      end
      call_buttons = m;
      m_pend = m_pend | m;
      tick();
      call_buttons = '0;
      tick();
      pick(m_pend, m_car, m_dir, tgt, nd);
      m_dir = nd;
      chk("rnd_req", 32'(bus.request), 1);
      chk("rnd_flr", 32'(bus.requested_floor), tgt);
      chk("rnd_dir", 32'(direction), 32'(m_dir));

      w = ($urandom_range(0, 4) == 0) ? AT : $urandom_range(0, 5);
      for (int c = 1; c <= w; c++) begin
        cb = ($urandom_range(0, 3) == 0) ? NF'($urandom) : '0;
        call_buttons = cb;
        bus.arrived  = ($urandom_range(0, 3) == 0);
        m_pend = m_pend | cb;
        tick();
        call_buttons = '0;
        bus.arrived  = 1'b0;
        chk("rnd_wpend", 32'(pending), 32'(m_pend));
        if (c < AT) begin
          chk("rnd_wreq", 32'(bus.request), 1);
          chk("rnd_wflr", 32'(bus.requested_floor), tgt);
        end else begin
          chk("rnd_tmo", 32'(bus.request), 0);
        end
      end
      if (w == AT) begin
        tick();
        pick(m_pend, m_car, m_dir, tgt, nd);
        m_dir = nd;
        chk("rnd_rsel", 32'(bus.requested_floor), tgt);
        chk("rnd_rdir", 32'(direction), 32'(m_dir));
      end

      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      chk("rnd_ack", 32'(bus.request), 0);
      k = $urandom_range(0, 3);
      for (int c = 0; c < k; c++) begin
        cb = NF'($urandom);
        call_buttons = cb;
        m_pend = m_pend | cb;
        tick();
        call_buttons = '0;
        chk("rnd_wa_busy", 32'(busy), 1);
      end

      cb = ($urandom_range(0, 1) == 0) ? NF'($urandom) : '0;
      call_buttons = cb;
      car_floor    = 3'(tgt);
      bus.arrived  = 1'b1;
      m_pend = (m_pend | cb) & ~(NF'(1) << tgt);
      m_car  = tgt;
      tick();
      call_buttons = '0;
      bus.arrived  = 1'b0;
      chk("rnd_apend", 32'(pending), 32'(m_pend));
      chk("rnd_abusy", 32'(busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
